// File: rtl/test_status_wb.sv
// Wishbone test-status block: per-channel result/pass/fail registers, a console
// byte FIFO, and done/overflow status for a simulation or silicon self-test harness.
module test_status_wb #(
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned CNT_W      = 16
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  input  logic [3:0]  wb_sel_i,
  output logic        wb_ack_o,
  output logic        wb_err_o,
  output logic        wb_stall_o,
  output logic [31:0] wb_dat_o,
  output logic [7:0]  console_data_o,
  output logic        console_valid_o,
  input  logic        console_ready_i,
  output logic        done_o,
  output logic        any_fail_o
);

  localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned FCNT_W = PTR_W + 1;

  logic              ack_q, err_q;
  logic [31:0]       dat_q;
  logic [31:0]       last_q [NUM_CH];
  logic [31:0]       last_d [NUM_CH];
  logic [CNT_W-1:0]  pass_q [NUM_CH];
  logic [CNT_W-1:0]  pass_d [NUM_CH];
  logic [CNT_W-1:0]  fail_q [NUM_CH];
  logic [CNT_W-1:0]  fail_d [NUM_CH];
  logic              done_q, done_d;
  logic              ovf_q, ovf_d;
  logic [7:0]        mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [FCNT_W-1:0] count_q, count_d;

  logic        req_c, wr_c, mapped_c;
  logic        is_res_c, is_pass_c, is_fail_c, is_cons_c, is_stat_c, is_ctrl_c;
  logic [2:0]  grp_c, ch_c;
  logic        ch_ok_c;
  logic [31:0] rdata_c;
  logic        full_c, empty_c, push_c, pop_c, push_ok_c;
  logic        clr_c, set_c;
  logic        unused_c;

  assign unused_c = ^{wb_adr_i[31:8], wb_adr_i[1:0], wb_sel_i[3:1]};

  // A new request is only accepted once the previous response has retired
  assign req_c   = wb_cyc_i & wb_stb_i & ~ack_q & ~err_q;
  assign grp_c   = wb_adr_i[7:5];
  assign ch_c    = wb_adr_i[4:2];
  assign ch_ok_c = 32'(ch_c) < NUM_CH;

  always_comb begin
    is_res_c  = 1'b0;
    is_pass_c = 1'b0;
    is_fail_c = 1'b0;
    is_cons_c = 1'b0;
    is_stat_c = 1'b0;
    is_ctrl_c = 1'b0;
    case (grp_c)
      3'd0: is_res_c  = ch_ok_c;
      3'd2: is_pass_c = ch_ok_c;
      3'd3: is_fail_c = ch_ok_c;
      3'd4: begin
        is_cons_c = (ch_c == 3'd0);
        is_stat_c = (ch_c == 3'd1);
        is_ctrl_c = (ch_c == 3'd2);
      end
      default: ;
    endcase
  end

  assign mapped_c = is_res_c | is_pass_c | is_fail_c | is_cons_c | is_stat_c | is_ctrl_c;
  assign wr_c     = req_c & wb_we_i & mapped_c;
  assign clr_c    = wr_c & is_ctrl_c & wb_dat_i[1];
  assign set_c    = wr_c & is_ctrl_c & wb_dat_i[0];

  assign full_c    = (count_q == FCNT_W'(FIFO_DEPTH));
  assign empty_c   = (count_q == '0);
  assign pop_c     = ~empty_c & console_ready_i;
  assign push_c    = wr_c & is_cons_c & wb_sel_i[0];
  assign push_ok_c = push_c & (~full_c | pop_c);

  // Read mux; sampled into dat_q in the request cycle
  always_comb begin
    rdata_c = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_c == 3'(i)) begin
        if (is_res_c)  rdata_c = last_q[i];
        if (is_pass_c) rdata_c = 32'(pass_q[i]);
        if (is_fail_c) rdata_c = 32'(fail_q[i]);
      end
    end
    if (is_stat_c) rdata_c = {12'b0, 4'(NUM_CH), 8'(count_q), 4'b0, ovf_q, full_c, empty_c, done_q};
    if (is_ctrl_c) rdata_c = {31'b0, done_q};
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      ack_q <= 1'b0;
      err_q <= 1'b0;
      dat_q <= '0;
    end else begin
      ack_q <= req_c & mapped_c;
      err_q <= req_c & ~mapped_c;
      dat_q <= (req_c & mapped_c & ~wb_we_i) ? rdata_c : '0;
    end
  end

  // Channel results and done; a clear and a set in one write leave done set
  always_comb begin
    last_d = last_q;
    pass_d = pass_q;
    fail_d = fail_q;
    done_d = done_q;
    if (clr_c) begin
      for (int i = 0; i < NUM_CH; i++) begin
        last_d[i] = '0;
        pass_d[i] = '0;
        fail_d[i] = '0;
      end
      done_d = 1'b0;
    end
    if (set_c) done_d = 1'b1;
    if (wr_c & is_res_c) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (ch_c == 3'(i)) begin
          last_d[i] = wb_dat_i;
          if (wb_dat_i == 32'd1) begin
            if (pass_q[i] != '1) pass_d[i] = pass_q[i] + CNT_W'(1);
          end else begin
            if (fail_q[i] != '1) fail_d[i] = fail_q[i] + CNT_W'(1);
          end
        end
      end
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      for (int i = 0; i < NUM_CH; i++) begin
        last_q[i] <= '0;
        pass_q[i] <= '0;
        fail_q[i] <= '0;
      end
      done_q <= 1'b0;
    end else begin
      last_q <= last_d;
      pass_q <= pass_d;
      fail_q <= fail_d;
      done_q <= done_d;
    end
  end

  // Console FIFO pointers, occupancy and sticky overflow
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (push_ok_c) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_c)     rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push_ok_c, pop_c})
      2'b10:   count_d = count_q + FCNT_W'(1);
      2'b01:   count_d = count_q - FCNT_W'(1);
      default: ;
    endcase
    if (wr_c & is_stat_c & wb_dat_i[3]) ovf_d = 1'b0;
    if (push_c & full_c & ~pop_c)       ovf_d = 1'b1;
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (push_ok_c) mem_q[wr_ptr_q] <= wb_dat_i[7:0];
  end

  always_comb begin
    any_fail_o = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (fail_q[i] != '0) any_fail_o = 1'b1;
    end
  end

  assign wb_ack_o        = ack_q;
  assign wb_err_o        = err_q;
  assign wb_stall_o      = 1'b0;
  assign wb_dat_o        = dat_q;
  assign console_data_o  = mem_q[rd_ptr_q];
  assign console_valid_o = ~empty_c;
  assign done_o          = done_q;

endmodule

// File: tb/tb_test_status_wb.sv
// Directed bench for test_status_wb: register map, counters, console FIFO
// full/overflow/wrap behaviour, and reset abort of an in-flight write.
module tb_test_status_wb;

  logic        wb_clk_i;
  logic        wb_rst_i;
  logic        wb_cyc_i, wb_stb_i, wb_we_i;
  logic [31:0] wb_adr_i, wb_dat_i;
  logic [3:0]  wb_sel_i;
  logic        wb_ack_o, wb_err_o, wb_stall_o;
  logic [31:0] wb_dat_o;
  logic [7:0]  console_data_o;
  logic        console_valid_o, console_ready_i;
  logic        done_o, any_fail_o;

  int n_vec = 0;
  int n_err = 0;

  test_status_wb #(.NUM_CH(4), .FIFO_DEPTH(16), .CNT_W(2)) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
    .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i),
    .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_sel_i(wb_sel_i),
    .wb_ack_o(wb_ack_o), .wb_err_o(wb_err_o), .wb_stall_o(wb_stall_o),
    .wb_dat_o(wb_dat_o),
    .console_data_o(console_data_o), .console_valid_o(console_valid_o),
    .console_ready_i(console_ready_i),
    .done_o(done_o), .any_fail_o(any_fail_o)
  );

  initial begin
    wb_clk_i = 1'b0;
    forever #5 wb_clk_i = ~wb_clk_i;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One classic cycle; rdy drives console_ready_i only during the request cycle
  task automatic bus(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                     input logic [3:0] sel, input logic rdy,
                     output logic ack, output logic err, output logic [31:0] rd);
    @(posedge wb_clk_i); #1;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we;
    wb_adr_i = adr; wb_dat_i = dat; wb_sel_i = sel;
    console_ready_i = rdy;
    check("resp_before_edge", {30'b0, wb_ack_o, wb_err_o}, 32'h0);
    @(posedge wb_clk_i); #1;
    console_ready_i = 1'b0;
    ack = wb_ack_o; err = wb_err_o; rd = wb_dat_o;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    @(posedge wb_clk_i); #1;
    check("resp_one_cycle", {30'b0, wb_ack_o, wb_err_o}, 32'h0);
  endtask

  task automatic wr(input string tag, input logic [31:0] adr, input logic [31:0] dat,
                    input logic [3:0] sel, input logic rdy);
    logic a, e;
    logic [31:0] r;
    bus(1'b1, adr, dat, sel, rdy, a, e, r);
    check(tag, {30'b0, a, e}, 32'h2);
  endtask

  task automatic rd(input string tag, input logic [31:0] adr, input logic [31:0] exp);
    logic a, e;
    logic [31:0] r;
    bus(1'b0, adr, 32'h0, 4'hF, 1'b0, a, e, r);
    check({tag, "_ack"}, {30'b0, a, e}, 32'h2);
    check(tag, r, exp);
  endtask

  task automatic bad(input string tag, input logic we, input logic [31:0] adr);
    logic a, e;
    logic [31:0] r;
    bus(we, adr, 32'h1, 4'hF, 1'b0, a, e, r);
    check({tag, "_err"}, {30'b0, a, e}, 32'h1);
    check({tag, "_dat"}, r, 32'h0);
  endtask

  initial begin
    logic [7:0] exp_b;
    wb_rst_i = 1'b1; wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    wb_adr_i = '0; wb_dat_i = '0; wb_sel_i = '0; console_ready_i = 1'b0;
    repeat (2) @(posedge wb_clk_i);
    #1;
    check("rst_outputs", {26'b0, wb_ack_o, wb_err_o, console_valid_o, done_o, any_fail_o, wb_stall_o}, 32'h0);
    check("rst_dat", wb_dat_o, 32'h0);
    @(negedge wb_clk_i); wb_rst_i = 1'b0;

    // Result writes and counters
    rd ("status_init", 32'h84, 32'h0004_0002);
    wr ("res0_pass", 32'h00, 32'h1, 4'hF, 1'b0);
    wr ("res1_fail", 32'h04, 32'hDEAD, 4'h1, 1'b0);
    rd ("pass0", 32'h40, 32'h1);
    rd ("fail1", 32'h64, 32'h1);
    rd ("fail0", 32'h60, 32'h0);
    check("any_fail_set", {31'b0, any_fail_o}, 32'h1);
    rd ("last1", 32'h04, 32'hDEAD);
    rd ("last0", 32'h00, 32'h1);

    // Unmapped: channel beyond NUM_CH and holes in the map
    bad("rd_res4", 1'b0, 32'h10);
    bad("wr_res4", 1'b1, 32'h10);
    bad("rd_8c", 1'b0, 32'h8C);
    bad("rd_20", 1'b0, 32'h20);
    rd ("fail2_unchanged", 32'h68, 32'h0);
    rd ("pass0_unchanged", 32'h40, 32'h1);

    // Counter writes ignored; 2-bit pass counter saturates at 3
    wr ("pass0_wr", 32'h40, 32'h55, 4'hF, 1'b0);
    rd ("pass0_ro", 32'h40, 32'h1);
    for (int i = 0; i < 4; i++) wr("res0_more", 32'h00, 32'h1, 4'hF, 1'b0);
    rd ("pass0_sat", 32'h40, 32'h3);

    // Fill FIFO with ready low: 16 accepted, 17th dropped with overflow
    for (int i = 0; i < 17; i++) wr("push", 32'h80, 32'(16 + i), 4'h1, 1'b0);
    rd ("status_full_ovf", 32'h84, 32'h0004_100C);
    check("head_full", {24'b0, console_data_o}, 32'h10);
    wr ("ovf_clr", 32'h84, 32'h8, 4'hF, 1'b0);
    rd ("status_ovf_clr", 32'h84, 32'h0004_1004);

    // Push into full FIFO with a same-cycle pop
    wr ("push_pop", 32'h80, 32'hA5, 4'h1, 1'b1);
    rd ("status_push_pop", 32'h84, 32'h0004_1004);

    // Drain and check order across pointer wrap
    for (int i = 0; i < 16; i++) begin
      exp_b = (i < 15) ? 8'(8'h11 + i) : 8'hA5;
      check("drain_valid", {31'b0, console_valid_o}, 32'h1);
      check("drain_data", {24'b0, console_data_o}, {24'b0, exp_b});
      console_ready_i = 1'b1;
      @(posedge wb_clk_i); #1;
      console_ready_i = 1'b0;
    end
    check("drained_empty", {31'b0, console_valid_o}, 32'h0);

    // Console write without sel[0] pushes nothing; console reads 0
    wr ("cons_nosel", 32'h80, 32'h77, 4'hE, 1'b0);
    check("cons_nosel_empty", {31'b0, console_valid_o}, 32'h0);
    rd ("cons_rd", 32'h80, 32'h0);

    // Done set / no-op write / status
    wr ("done_set", 32'h88, 32'h1, 4'hF, 1'b0);
    check("done_o_set", {31'b0, done_o}, 32'h1);
    wr ("done_wr0", 32'h88, 32'h0, 4'hF, 1'b0);
    rd ("ctrl_rd", 32'h88, 32'h1);
    rd ("status_done", 32'h84, 32'h0004_0003);

    // Global clear
    wr ("clear", 32'h88, 32'h2, 4'hF, 1'b0);
    rd ("pass0_clr", 32'h40, 32'h0);
    rd ("fail1_clr", 32'h64, 32'h0);
    rd ("last1_clr", 32'h04, 32'h0);
    check("any_fail_clr", {31'b0, any_fail_o}, 32'h0);
    check("done_clr", {31'b0, done_o}, 32'h0);

    // Reset asserted during the request cycle of a done-set write
    @(posedge wb_clk_i); #1;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1;
    wb_adr_i = 32'h88; wb_dat_i = 32'h1; wb_sel_i = 4'hF;
    #2 wb_rst_i = 1'b1;
    @(posedge wb_clk_i); #1;
    check("rst_abort_resp", {30'b0, wb_ack_o, wb_err_o}, 32'h0);
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    #2 wb_rst_i = 1'b0;
    repeat (2) @(posedge wb_clk_i);
    #1;
    check("rst_abort_noack", {30'b0, wb_ack_o, wb_err_o}, 32'h0);
    check("rst_abort_done", {31'b0, done_o}, 32'h0);
    wr ("post_rst_res", 32'h08, 32'h1, 4'hF, 1'b0);
    rd ("post_rst_pass2", 32'h48, 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
